// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_count FIFO family.
// Pointer/count sizing and wrap-aware pointer increment.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Explicit wrap so non-power-of-two depths never rely on overflow.
    function automatic int unsigned ptr_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_count_ram.sv
// DEPTH x WIDTH storage: synchronous write, async or registered read.
// Storage is never reset; only the registered read data is.
module fifo_count_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter bit REG_READ = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    re,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_async
            assign rdata = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/fifo_count.sv
// Synchronous FIFO with occupancy count, almost flags and flush.
// Optional sticky overflow/underflow outputs under FIFO_ERR_FLAGS_EN.
module fifo_count
    import fifo_pkg::*;
#(
    parameter int WIDTH                  = 8,
    parameter int DEPTH                  = 4,
    parameter int FIRST_WORD_FALLTHROUGH = 0,
    parameter int AF_LEVEL               = DEPTH - 1,
    parameter int AE_LEVEL               = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        din,
    output logic                    full,
    output logic                    almost_full,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        dout,
    output logic                    empty,
    output logic                    almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                    overflow,
    output logic                    underflow,
`endif
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic             blk;
    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] rdata;
    fifo_status_t     st;

    always_comb begin
        st.empty        = (cnt == '0);
        st.full         = (cnt == DEPTH_C);
        st.almost_empty = (cnt <= AE_C);
        st.almost_full  = (cnt >= AF_C);
    end

    // Reset and flush both block acceptance of any request that cycle.
    assign blk    = rst || flush;
    assign rd_acc = rd_en && !st.empty && !blk;
    assign wr_acc = wr_en && (!st.full || rd_acc) && !blk;

    always_ff @(posedge clk) begin
        if (blk) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (wr_acc) begin
                tail <= PW'(ptr_inc(32'(tail), 32'(DEPTH)));
            end
            if (rd_acc) begin
                head <= PW'(ptr_inc(32'(head), 32'(DEPTH)));
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (blk) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    fifo_count_ram #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .REG_READ (FIRST_WORD_FALLTHROUGH == 0)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (tail),
        .wdata (din),
        .re    (rd_acc),
        .raddr (head),
        .rdata (rdata)
    );

    assign dout = (FIRST_WORD_FALLTHROUGH != 0 && st.empty) ? '0 : rdata;

    assign count        = cnt;
    assign empty        = st.empty;
    assign full         = st.full;
    assign almost_empty = st.almost_empty;
    assign almost_full  = st.almost_full;

endmodule

// File: tb/tb_fifo_count.sv
// Scoreboard bench for fifo_count: DEPTH=4 and DEPTH=5 registered,
// plus a DEPTH=4 first-word-fallthrough instance.
module tb_fifo_count;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic flush = 1'b0;

    logic       wr4 = 0, rd4 = 0;
    logic [7:0] din4 = 0, dout4;
    logic       full4, af4, empty4, ae4;
    logic [2:0] cnt4;

    logic       wr5 = 0, rd5 = 0;
    logic [7:0] din5 = 0, dout5;
    logic       full5, af5, empty5, ae5;
    logic [2:0] cnt5;

    logic       wrf = 0, rdf = 0;
    logic [7:0] dinf = 0, doutf;
    logic       fullf, aff, emptyf, aef;
    logic [2:0] cntf;

`ifdef FIFO_ERR_FLAGS_EN
    logic ov4, uf4, ov5, uf5, ovf, uff;
`endif

    fifo_count #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr4), .din(din4), .full(full4), .almost_full(af4),
        .rd_en(rd4), .dout(dout4), .empty(empty4), .almost_empty(ae4),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow(ov4), .underflow(uf4),
`endif
        .count(cnt4)
    );

    fifo_count #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr5), .din(din5), .full(full5), .almost_full(af5),
        .rd_en(rd5), .dout(dout5), .empty(empty5), .almost_empty(ae5),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow(ov5), .underflow(uf5),
`endif
        .count(cnt5)
    );

    fifo_count #(.WIDTH(8), .DEPTH(4), .FIRST_WORD_FALLTHROUGH(1)) dutf (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wrf), .din(dinf), .full(fullf), .almost_full(aff),
        .rd_en(rdf), .dout(doutf), .empty(emptyf), .almost_empty(aef),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow(ovf), .underflow(uff),
`endif
        .count(cntf)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q4[$];
    logic [7:0] q5[$];
    logic [7:0] qf[$];
    logic [7:0] m4 = 0;
    logic [7:0] m5 = 0;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q4.delete(); q5.delete(); qf.delete();
        m4 = 0; m5 = 0;
        @(negedge clk);
    endtask

    task automatic step4(input logic w, input logic r, input logic [7:0] d);
        bit ra, wa;
        ra = r && q4.size() > 0 && !flush && !rst;
        wa = w && (q4.size() < 4 || ra) && !flush && !rst;
        wr4 = w; rd4 = r; din4 = d;
        @(posedge clk); #1;
        if (rst) begin
            q4.delete(); m4 = 0;
        end else if (flush) begin
            q4.delete();
        end else begin
            if (ra) m4 = q4.pop_front();
            if (wa) q4.push_back(d);
        end
        wr4 = 0; rd4 = 0;
        @(negedge clk);
    endtask

    task automatic step5(input logic w, input logic r, input logic [7:0] d);
        bit ra, wa;
        ra = r && q5.size() > 0;
        wa = w && (q5.size() < 5 || ra);
        wr5 = w; rd5 = r; din5 = d;
        @(posedge clk); #1;
        if (ra) m5 = q5.pop_front();
        if (wa) q5.push_back(d);
        wr5 = 0; rd5 = 0;
        @(negedge clk);
    endtask

    task automatic stepf(input logic w, input logic r, input logic [7:0] d);
        bit ra, wa;
        ra = r && qf.size() > 0;
        wa = w && (qf.size() < 4 || ra);
        wrf = w; rdf = r; dinf = d;
        @(posedge clk); #1;
        if (ra) void'(qf.pop_front());
        if (wa) qf.push_back(d);
        wrf = 0; rdf = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cnt4 !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", cnt4); end
        n_cmp++; if ({empty4, full4, ae4, af4} !== 4'b1010) begin n_err++; $display("FAIL reset_flags got %b want 1010", {empty4, full4, ae4, af4}); end
        n_cmp++; if (dout4 !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", dout4); end
        n_cmp++; if (doutf !== 8'h00) begin n_err++; $display("FAIL reset_fwft_dout got %h want 00", doutf); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h11 * (i + 1));
            step4(1, 0, d);
            n_cmp++; if (cnt4 !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count got %0d want %0d", cnt4, i + 1); end
            n_cmp++; if ({full4, af4, ae4} !== {i == 3, i >= 2, i == 0}) begin n_err++; $display("FAIL fill_flags got %b want %b", {full4, af4, ae4}, {i == 3, i >= 2, i == 0}); end
        end
        for (int i = 0; i < 4; i++) begin
            step4(0, 1, 8'h00);
            n_cmp++; if (dout4 !== m4 || dout4 !== 8'(8'h11 * (i + 1))) begin n_err++; $display("FAIL drain_dout got %h want %h", dout4, m4); end
            n_cmp++; if (cnt4 !== 3'(3 - i)) begin n_err++; $display("FAIL drain_count got %0d want %0d", cnt4, 3 - i); end
        end
        n_cmp++; if (empty4 !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty4); end
    endtask

    task automatic test_full_passthru();
        do_reset();
        for (int i = 0; i < 4; i++) step4(1, 0, 8'(8'h11 * (i + 1)));
        step4(1, 1, 8'h55);
        n_cmp++; if (dout4 !== m4) begin n_err++; $display("FAIL pass_dout got %h want %h", dout4, m4); end
        n_cmp++; if (cnt4 !== 3'd4 || full4 !== 1'b1) begin n_err++; $display("FAIL pass_count got %0d/%b want 4/1", cnt4, full4); end
        for (int i = 0; i < 4; i++) begin
            step4(0, 1, 8'h00);
            n_cmp++; if (dout4 !== m4) begin n_err++; $display("FAIL pass_read got %h want %h", dout4, m4); end
        end
        n_cmp++; if (dout4 !== 8'h55) begin n_err++; $display("FAIL pass_last got %h want 55", dout4); end
    endtask

    task automatic test_empty_rw();
        step4(1, 1, 8'hAA);
        n_cmp++; if (cnt4 !== 3'd1) begin n_err++; $display("FAIL erw_count got %0d want 1", cnt4); end
        n_cmp++; if (dout4 !== m4 || dout4 !== 8'h55) begin n_err++; $display("FAIL erw_dout got %h want 55", dout4); end
        step4(0, 1, 8'h00);
        n_cmp++; if (dout4 !== 8'hAA) begin n_err++; $display("FAIL erw_read got %h want aa", dout4); end
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 4; i++) step4(1, 0, 8'(8'hA0 + i));
        step4(1, 0, 8'hEE);
        n_cmp++; if (cnt4 !== 3'd4 || full4 !== 1'b1) begin n_err++; $display("FAIL ovf_count got %0d want 4", cnt4); end
        for (int i = 0; i < 4; i++) begin
            step4(0, 1, 8'h00);
            n_cmp++; if (dout4 !== m4) begin n_err++; $display("FAIL ovf_read got %h want %h", dout4, m4); end
        end
        step4(0, 1, 8'h00);
        n_cmp++; if (cnt4 !== 3'd0 || dout4 !== 8'hA3) begin n_err++; $display("FAIL udf_hold got %0d/%h want 0/a3", cnt4, dout4); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) step4(1, 0, 8'(8'h61 + i));
        step4(0, 1, 8'h00);
        n_cmp++; if (cnt4 !== 3'd3) begin n_err++; $display("FAIL flush_pre got %0d want 3", cnt4); end
        flush = 1'b1;
        step4(1, 0, 8'h99);
        flush = 1'b0;
        n_cmp++; if ({cnt4, empty4, ae4} !== {3'd0, 2'b11}) begin n_err++; $display("FAIL flush_state got %0d/%b/%b want 0/1/1", cnt4, empty4, ae4); end
        n_cmp++; if (dout4 !== 8'h61) begin n_err++; $display("FAIL flush_hold got %h want 61", dout4); end
        step4(1, 0, 8'h77);
        step4(0, 1, 8'h00);
        n_cmp++; if (dout4 !== 8'h77 || cnt4 !== 3'd0) begin n_err++; $display("FAIL flush_after got %h/%0d want 77/0", dout4, cnt4); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) step4(1, 0, 8'(8'hC0 + i));
        step4(0, 1, 8'h00);
        rst = 1'b1;
        step4(1, 0, 8'hCC);
        rst = 1'b0;
        n_cmp++; if (cnt4 !== 3'd0 || dout4 !== 8'h00) begin n_err++; $display("FAIL rstmid_state got %0d/%h want 0/00", cnt4, dout4); end
        n_cmp++; if ({empty4, full4, ae4, af4} !== 4'b1010) begin n_err++; $display("FAIL rstmid_flags got %b want 1010", {empty4, full4, ae4, af4}); end
        step4(0, 1, 8'h00);
        n_cmp++; if (dout4 !== 8'h00 || cnt4 !== 3'd0) begin n_err++; $display("FAIL rstmid_stale got %h/%0d want 00/0", dout4, cnt4); end
    endtask

    task automatic test_depth5();
        do_reset();
        for (int i = 0; i < 5; i++) step5(1, 0, 8'(8'h50 + i));
        n_cmp++; if (cnt5 !== 3'd5 || full5 !== 1'b1) begin n_err++; $display("FAIL d5_full got %0d/%b want 5/1", cnt5, full5); end
        for (int i = 0; i < 3; i++) begin
            step5(0, 1, 8'h00);
            n_cmp++; if (dout5 !== m5) begin n_err++; $display("FAIL d5_read got %h want %h", dout5, m5); end
        end
        for (int i = 0; i < 3; i++) begin
            step5(1, 0, 8'(8'h60 + i));
            n_cmp++; if (cnt5 !== 3'(3 + i)) begin n_err++; $display("FAIL d5_wrap_count got %0d want %0d", cnt5, 3 + i); end
        end
        step5(1, 0, 8'hFF);
        n_cmp++; if (cnt5 !== 3'd5) begin n_err++; $display("FAIL d5_cap got %0d want 5", cnt5); end
        for (int i = 0; i < 5; i++) begin
            step5(0, 1, 8'h00);
            n_cmp++; if (dout5 !== m5) begin n_err++; $display("FAIL d5_order got %h want %h", dout5, m5); end
        end
        n_cmp++; if (dout5 !== 8'h62 || empty5 !== 1'b1) begin n_err++; $display("FAIL d5_last got %h/%b want 62/1", dout5, empty5); end
    endtask

    task automatic test_fwft();
        do_reset();
        n_cmp++; if (doutf !== 8'h00 || emptyf !== 1'b1) begin n_err++; $display("FAIL fwft_empty got %h want 00", doutf); end
        stepf(1, 1, 8'hAA);
        n_cmp++; if (doutf !== 8'hAA || cntf !== 3'd1) begin n_err++; $display("FAIL fwft_first got %h/%0d want aa/1", doutf, cntf); end
        stepf(1, 0, 8'hBB);
        n_cmp++; if (doutf !== qf[0]) begin n_err++; $display("FAIL fwft_hold got %h want %h", doutf, qf[0]); end
        stepf(0, 1, 8'h00);
        n_cmp++; if (doutf !== 8'hBB || cntf !== 3'd1) begin n_err++; $display("FAIL fwft_next got %h/%0d want bb/1", doutf, cntf); end
        stepf(0, 1, 8'h00);
        n_cmp++; if (doutf !== 8'h00 || emptyf !== 1'b1) begin n_err++; $display("FAIL fwft_drain got %h want 00", doutf); end
    endtask

`ifdef FIFO_ERR_FLAGS_EN
    task automatic test_err_flags();
        do_reset();
        step4(0, 1, 8'h00);
        step4(1, 0, 8'h01);
        n_cmp++; if ({ov4, uf4} !== 2'b01) begin n_err++; $display("FAIL uf_sticky got %b want 01", {ov4, uf4}); end
        do_reset();
        n_cmp++; if ({ov4, uf4} !== 2'b00) begin n_err++; $display("FAIL err_reset got %b want 00", {ov4, uf4}); end
        for (int i = 0; i < 5; i++) step4(1, 0, 8'(i));
        n_cmp++; if ({ov4, uf4} !== 2'b10) begin n_err++; $display("FAIL ovf_flag got %b want 10", {ov4, uf4}); end
        flush = 1'b1;
        step4(0, 0, 8'h00);
        flush = 1'b0;
        n_cmp++; if ({ov4, uf4} !== 2'b00) begin n_err++; $display("FAIL err_flush got %b want 00", {ov4, uf4}); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_full_passthru();
        test_empty_rw();
        test_drop();
        test_flush();
        test_reset_mid();
        test_depth5();
        test_fwft();
`ifdef FIFO_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
